// File: rtl/mic1_run_ctrl.sv
// mic1_run_ctrl -- run/stop/step controller for the MIC-1 core on the FPGA board.
//
// Debounces the four board buttons, turns each accepted press into a single
// one-cycle pulse, and runs a four-state FSM (IDLE, RUN, STEP, HALT) that gates
// the core clock enable. A step press issues a burst of STEP_N enabled cycles.
// A synchronised halt level from the core parks the controller in HALT until
// clear is pressed.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   resetn    asynchronous reset, active HIGH despite the name
//   btn_run   raw run button (Up)
//   btn_step  raw step button (Right)
//   btn_stop  raw stop button (Down)
//   btn_clr   raw clear button (Center)
//   halt_in   level from the core, 1 = core executed halt
//   run_en    core clock enable, high in RUN or STEP
//   led_run   1 in RUN or STEP
//   led_idle  1 in IDLE
//   led_halt  1 in HALT
//   cnt       number of enabled cycles issued, wraps modulo 2^CNT_W
module mic1_run_ctrl #(
   parameter int DB_CYCLES = 1000000,
   parameter int STEP_N    = 1,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_stop,
   input  logic             btn_clr,
   input  logic             halt_in,
   output logic             run_en,
   output logic             led_run,
   output logic             led_idle,
   output logic             led_halt,
   output logic [CNT_W-1:0] cnt
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int SL_W = $clog2(STEP_N + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;
   localparam logic [1:0] S_HALT = 2'd3;

   // Bit positions of the buttons inside the packed front-end vectors.
   localparam int B_RUN  = 0;
   localparam int B_STEP = 1;
   localparam int B_STOP = 2;
   localparam int B_CLR  = 3;

   logic [3:0]      btn_raw;
   logic [3:0]      sync1, sync2;
   logic [3:0]      db, db_d;
   logic [DB_W-1:0] db_cnt [4];
   logic [3:0]      press;
   logic            halt_m, halt_s;

   logic [1:0]      state;
   logic [SL_W-1:0] step_left;

   assign btn_raw = {btn_clr, btn_stop, btn_step, btn_run};

   // Button front end. db_cnt counts consecutive cycles in which the
   // synchronised level disagrees with the accepted level; agreement (a bounce
   // back) clears it, so only a level held for DB_CYCLES samples is accepted.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         halt_m <= 1'b0;
         halt_s <= 1'b0;
         // NOTE: the counter array is plain flops, not RAM, so it is reset
         // element by element like any other register.
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1  <= btn_raw;
         sync2  <= sync1;
         db_d   <= db;
         halt_m <= halt_in;
         halt_s <= halt_m;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // One pulse per accepted rising level; a held button or a release gives none.
   assign press = db & ~db_d;

   // Enable and LEDs decode straight from the state register, so they are
   // free of combinational glitches.
   assign run_en   = (state == S_RUN) || (state == S_STEP);
   assign led_run  = run_en;
   assign led_idle = (state == S_IDLE);
   assign led_halt = (state == S_HALT);

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state     <= S_IDLE;
         step_left <= '0;
         cnt       <= '0;
      end else begin
         if (run_en) begin
            cnt <= cnt + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (press[B_CLR]) begin
                  cnt <= '0;
               end else if (press[B_RUN]) begin
                  state <= S_RUN;
               end else if (press[B_STEP]) begin
                  state     <= S_STEP;
                  step_left <= SL_W'(STEP_N);
               end
            end
            S_RUN: begin
               if (halt_s) begin
                  state <= S_HALT;
               end else if (press[B_STOP]) begin
                  state <= S_IDLE;
               end
            end
            S_STEP: begin
               if (halt_s) begin
                  state     <= S_HALT;
                  step_left <= '0;
               end else if (press[B_STOP]) begin
                  state     <= S_IDLE;
                  step_left <= '0;
               end else if (step_left <= SL_W'(1)) begin
                  // Last cycle of the burst (the <= also recovers from a zero count).
                  state     <= S_IDLE;
                  step_left <= '0;
               end else begin
                  step_left <= step_left - SL_W'(1);
               end
            end
            S_HALT: begin
               if (press[B_CLR]) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state     <= S_IDLE;
               step_left <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Directed bench for mic1_run_ctrl. Two instances share all inputs: u_dut has
// STEP_N=3 and u_dut4 has STEP_N=4; both use DB_CYCLES=4 and CNT_W=4.
// With DB_CYCLES=4, a button driven high at a falling edge gives a press pulse
// after the 6th rising edge, and the FSM reacts at the 7th. The first falling
// edge that shows the new state is therefore loop index 6, where index 0 is
// the first falling edge after the button changed.
module tb_mic1_run_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       btn_run = 1'b0, btn_step = 1'b0, btn_stop = 1'b0, btn_clr = 1'b0;
   logic       halt_in = 1'b0;
   logic       run_en, led_run, led_idle, led_halt;
   logic [3:0] cnt;
   logic       run_en4, led_run4, led_idle4, led_halt4;
   logic [3:0] cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mic1_run_ctrl #(.DB_CYCLES(4), .STEP_N(3), .CNT_W(4)) u_dut (
      .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
      .btn_stop(btn_stop), .btn_clr(btn_clr), .halt_in(halt_in),
      .run_en(run_en), .led_run(led_run), .led_idle(led_idle),
      .led_halt(led_halt), .cnt(cnt)
   );

   mic1_run_ctrl #(.DB_CYCLES(4), .STEP_N(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
      .btn_stop(btn_stop), .btn_clr(btn_clr), .halt_in(halt_in),
      .run_en(run_en4), .led_run(led_run4), .led_idle(led_idle4),
      .led_halt(led_halt4), .cnt(cnt4)
   );

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({run_en, led_run, led_idle, led_halt} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0010", {run_en, led_run, led_idle, led_halt});
      end
      checks++;
      if (cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", cnt);
      end
      checks++;
      if ({run_en4, led_idle4, cnt4} !== {1'b0, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL reset_dut4: run_en=%b led_idle=%b cnt=%0d expected 0 1 0", run_en4, led_idle4, cnt4);
      end
      resetn = 1'b0;
      settle(2);
   endtask

   // Run press held ~10 cycles; cnt must count 0..15, wrap to 0 and keep going.
   task automatic test_run_wrap;
      int first_run = -1;
      int exp_cnt = 0;
      btn_run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 10) btn_run = 1'b0;
         if (run_en === 1'b1) begin
            if (first_run < 0) first_run = i;
            checks++;
            if (cnt !== 4'(exp_cnt)) begin
               errors++;
               $display("FAIL run_cnt: cycle %0d got %0d expected %0d", i, cnt, exp_cnt % 16);
            end
            checks++;
            if ({led_run, led_idle, led_halt} !== 3'b100) begin
               errors++;
               $display("FAIL run_leds: got %b expected 100", {led_run, led_idle, led_halt});
            end
            exp_cnt++;
         end else if (first_run >= 0) begin
            checks++;
            errors++;
            $display("FAIL run_continuous: run_en dropped at cycle %0d", i);
         end
      end
      checks++;
      if (first_run != 6) begin
         errors++;
         $display("FAIL run_latency: got %0d expected 6", first_run);
      end
      checks++;
      if (exp_cnt != 34) begin
         errors++;
         $display("FAIL run_cycles: got %0d expected 34", exp_cnt);
      end
   endtask

   // Stop from RUN: cnt was 1 on entry and gains 7 more before the FSM leaves RUN.
   task automatic test_stop;
      logic [3:0] frozen;
      frozen = 4'd0;
      btn_stop = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) btn_stop = 1'b0;
         if (i < 6) begin
            checks++;
            if (run_en !== 1'b1) begin
               errors++;
               $display("FAIL stop_early: cycle %0d run_en got %b expected 1", i, run_en);
            end
         end else if (i == 6) begin
            frozen = cnt;
            checks++;
            if ({run_en, led_run, led_idle, led_halt} !== 4'b0010) begin
               errors++;
               $display("FAIL stop_state: got %b expected 0010", {run_en, led_run, led_idle, led_halt});
            end
            checks++;
            if (cnt !== 4'd8) begin
               errors++;
               $display("FAIL stop_cnt: got %0d expected 8", cnt);
            end
         end else begin
            checks++;
            if (cnt !== frozen || run_en !== 1'b0) begin
               errors++;
               $display("FAIL stop_frozen: cnt %0d run_en %b expected %0d 0", cnt, run_en, frozen);
            end
         end
      end
   endtask

   // Hold step for a long window: one burst only, then a re-press gives another.
   task automatic step_burst(input string tag, input logic [3:0] exp_cnt, input logic [3:0] exp_cnt4);
      int hi = 0;
      int hi4 = 0;
      int first = -1;
      btn_step = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (run_en === 1'b1) begin
            hi++;
            if (first < 0) first = i;
         end
         if (run_en4 === 1'b1) hi4++;
      end
      btn_step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (run_en === 1'b1) hi++;
         if (run_en4 === 1'b1) hi4++;
      end
      checks++;
      if (hi != 3 || first != 6) begin
         errors++;
         $display("FAIL %s_burst: %0d cycles from %0d expected 3 from 6", tag, hi, first);
      end
      checks++;
      if (hi4 != 4) begin
         errors++;
         $display("FAIL %s_burst4: got %0d cycles expected 4", tag, hi4);
      end
      checks++;
      if (cnt !== exp_cnt || cnt4 !== exp_cnt4) begin
         errors++;
         $display("FAIL %s_cnt: got %0d/%0d expected %0d/%0d", tag, cnt, cnt4, exp_cnt, exp_cnt4);
      end
      checks++;
      if (led_idle !== 1'b1) begin
         errors++;
         $display("FAIL %s_idle: led_idle got %b expected 1", tag, led_idle);
      end
   endtask

   task automatic test_step;
      step_burst("step1", 4'd11, 4'd12);
      step_burst("step2", 4'd14, 4'd0);
   endtask

   // Bounce every 2 cycles never reaches the 4-sample threshold.
   task automatic test_bounce;
      int first_run = -1;
      for (int i = 0; i < 26; i++) begin
         btn_run = (i < 20) && (((i / 2) % 2) == 0);
         @(negedge clk);
         checks++;
         if (run_en !== 1'b0) begin
            errors++;
            $display("FAIL bounce_idle: cycle %0d run_en got %b expected 0", i, run_en);
         end
      end
      btn_run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) btn_run = 1'b0;
         if (run_en === 1'b1 && first_run < 0) first_run = i;
      end
      checks++;
      if (first_run != 6 || run_en !== 1'b1) begin
         errors++;
         $display("FAIL bounce_run: first run at %0d run_en %b expected 6 1", first_run, run_en);
      end
   endtask

   // Halt and stop reach the FSM on the same edge; halt must win.
   task automatic test_halt;
      btn_stop = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 3) halt_in = 1'b1;
         if (i == 10) btn_stop = 1'b0;
         if (i < 6) begin
            checks++;
            if (run_en !== 1'b1) begin
               errors++;
               $display("FAIL halt_early: cycle %0d run_en got %b expected 1", i, run_en);
            end
         end else if (i == 6) begin
            checks++;
            if ({run_en, led_run, led_idle, led_halt} !== 4'b0001) begin
               errors++;
               $display("FAIL halt_enter: got %b expected 0001", {run_en, led_run, led_idle, led_halt});
            end
         end
      end
      halt_in = 1'b0;
      // Run and step presses must leave HALT untouched.
      for (int k = 0; k < 2; k++) begin
         if (k == 0) btn_run = 1'b1; else btn_step = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
               btn_run = 1'b0;
               btn_step = 1'b0;
            end
            checks++;
            if ({run_en, led_halt} !== 2'b01) begin
               errors++;
               $display("FAIL halt_hold: press %0d cycle %0d got %b expected 01", k, i, {run_en, led_halt});
            end
         end
      end
      btn_clr = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) btn_clr = 1'b0;
         if (i == 5) begin
            checks++;
            if (led_halt !== 1'b1) begin
               errors++;
               $display("FAIL clr_early: led_halt got %b expected 1", led_halt);
            end
         end
         if (i == 6) begin
            checks++;
            if ({led_idle, led_halt, run_en} !== 3'b100 || cnt !== 4'd0 || cnt4 !== 4'd0) begin
               errors++;
               $display("FAIL clr_exit: leds %b cnt %0d/%0d expected 100 0/0", {led_idle, led_halt, run_en}, cnt, cnt4);
            end
         end
      end
   endtask

   // Reset while u_dut4 has step_left=2, then a fresh step gives all 4 cycles.
   task automatic test_reset_mid_step;
      btn_step = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i >= 6) begin
            checks++;
            if (run_en4 !== 1'b1 || cnt4 !== 4'(i - 6)) begin
               errors++;
               $display("FAIL midstep_pre: cycle %0d run_en %b cnt %0d expected 1 %0d", i, run_en4, cnt4, i - 6);
            end
         end
      end
      btn_step = 1'b0;
      resetn = 1'b1;
      #1;
      checks++;
      if ({run_en4, led_idle4, run_en} !== 3'b010 || cnt4 !== 4'd0) begin
         errors++;
         $display("FAIL midstep_reset: run_en4 %b led_idle4 %b run_en %b cnt4 %0d expected 0 1 0 0", run_en4, led_idle4, run_en, cnt4);
      end
      @(negedge clk);
      resetn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (run_en4 !== 1'b0) begin
            errors++;
            $display("FAIL midstep_idle: cycle %0d run_en4 got %b expected 0", i, run_en4);
         end
      end
      step_burst("after_reset", 4'd3, 4'd4);
   endtask

   initial begin
      test_reset();
      test_run_wrap();
      test_stop();
      test_step();
      test_bounce();
      test_halt();
      test_reset_mid_step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
